debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
- REQ-001 The block SHALL have parameter NCH, default 8, giving the number of independent debounced channels (1..32).
- REQ-002 The block SHALL have parameter TICK_DIV, default 1000000, giving the clk cycles per sample tick (>=2; 20 ms at 50 MHz).
- REQ-003 The block SHALL have parameter STABLE_TICKS, default 2, giving the consecutive ticks an input must hold to be accepted (>=1).
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The block SHALL have port sw, input, NCH bits: raw switch/button levels, asynchronous to clk.
- REQ-007 The block SHALL have port level, output, NCH bits: debounced level per channel, registered.
- REQ-008 The block SHALL have port rise, output, NCH bits: one-cycle pulse when level goes 0->1.
- REQ-009 The block SHALL have port fall, output, NCH bits: one-cycle pulse when level goes 1->0.
- REQ-010 The block SHALL have port changed, output, 1 bit: OR of rise and fall, registered in the same cycle as the pulses.

Function
- REQ-011 The block SHALL run one shared prescaler (width ceil(log2(TICK_DIV))) counting 0..TICK_DIV-1, wrapping to 0, with tick=1 only when count==TICK_DIV-1.
- REQ-012 Each channel SHALL run its own FSM with states ZERO, WAIT1, ONE and WAIT0, plus a stable counter of width ceil(log2(STABLE_TICKS+1)).
- REQ-013 In ZERO, s=1 SHALL move the channel to WAIT1 with the stable count cleared; otherwise it stays in ZERO.
- REQ-014 In WAIT1, s=0 SHALL return the channel to ZERO with no pulse.
- REQ-015 In WAIT1, each tick with s=1 SHALL increment the stable count, and the tick at count==STABLE_TICKS-1 SHALL move the channel to ONE.
- REQ-016 In ONE, s=0 SHALL move the channel to WAIT0 with the stable count cleared.
- REQ-017 In WAIT0, s=1 SHALL return the channel to ONE with no pulse.
- REQ-018 In WAIT0, the tick at count==STABLE_TICKS-1 with s=0 SHALL move the channel to ZERO.
- REQ-019 level SHALL be 1 in ONE and WAIT0, and rise/fall SHALL assert exactly in the first cycle level shows the new value.
- REQ-020 Acceptance latency from the synchronized edge SHALL lie in [(STABLE_TICKS-1)*TICK_DIV+1, STABLE_TICKS*TICK_DIV] cycles.
- REQ-021 Channels SHALL be fully independent, and simultaneous transitions on any set of channels SHALL produce pulses in the same cycle.
- REQ-022 An input toggle in the same cycle as the accepting tick SHALL take priority over acceptance, so the channel returns to ZERO or ONE.
- REQ-023 rise and fall for one channel SHALL never assert together.

Reset
- REQ-024 reset_n=0 SHALL immediately force the prescaler to 0, every FSM to ZERO, every stable count to 0, synchronizer flops to 0, and level, rise, fall and changed to 0.
- REQ-025 Reset asserted mid-WAIT1 or mid-WAIT0 SHALL discard partial counts, with no pulse generated on reset entry or exit.
- REQ-026 After reset release, a channel whose sw is held high SHALL follow the normal ZERO->WAIT1->ONE path and produce a rise pulse.

Configuration
- REQ-027 With macro DEBOUNCE_SYNC_EN defined, each sw bit SHALL pass through a 2-flop synchronizer, adding 2 cycles latency, and s is the synchronizer output.
- REQ-028 Without DEBOUNCE_SYNC_EN, s SHALL be sw used directly, for inputs already synchronous to clk, and latency is reduced by 2 cycles.

Structure
- REQ-029 A shared package debounce_pkg SHALL hold the 2-bit state typedef (ZERO=00, WAIT0=01, ONE=10, WAIT1=11) and the width helper constants.
- REQ-030 The block SHALL contain one sub-module, debounce_chan, holding the per-channel FSM, stable counter and pulse registers, instantiated NCH times by generate.
- REQ-031 The prescaler and changed reduction SHALL reside in the top module.

Verification (NCH=4, TICK_DIV=4, STABLE_TICKS=3, DEBOUNCE_SYNC_EN defined)
- REQ-032 With sw[0] rising at cycle 10 and held -> level[0]=1 with a single-cycle rise[0] between cycles 21 and 24, and changed=1 that cycle.
- REQ-033 With sw[1] high for 5 cycles only -> level[1] stays 0 and no rise, fall or changed pulse occurs.
- REQ-034 With sw[2] and sw[3] rising the same cycle and held -> rise[2] and rise[3] assert in the same cycle, and changed is a single pulse.
- REQ-035 With channel 0 in ONE and sw[0] low for 6 cycles then high -> level[0] stays 1 and no fall[0] occurs.
- REQ-036 With channel 0 in ONE and sw[0] low and held -> fall[0] within 12 cycles plus 2 synchronizer cycles, and level[0]=0.
- REQ-037 With reset_n pulsed low while channel 1 is in WAIT1 -> all outputs 0 during reset, no pulse at release, and rise[1] occurs 11..14 cycles after release if sw[1] stays high.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce bank.
// The per-channel state encoding is fixed so that it reads the same in every
// tool and waveform viewer.
package debounce_pkg;

  // Per-channel debounce state. Bit 1 set means the accepted level is (or is
  // about to be confirmed as) the "high side" of the hysteresis loop.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } state_t;

  // ceil(log2(n)), never less than 1 so that every counter has at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the shared prescaler that counts 0..tick_div-1.
  function automatic int presc_width(input int tick_div);
    return clog2_min1(tick_div);
  endfunction

  // Width of a per-channel stable counter that must hold values up to stable_ticks.
  function automatic int stable_width(input int stable_ticks);
    return clog2_min1(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: four-state hysteresis FSM, stable-tick counter and
// registered level/rise/fall outputs. The accept strobe is exported so the top
// can register the bank-wide changed flag in the same cycle as the pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CW = stable_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Acceptance happens on the final required tick, and only while the input
  // still agrees with the pending level; a disagreeing input wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves accept unassigned (no latch).
    accept = 1'b0;
    if (tick && (cnt == LAST)) begin
      case (state)
        WAIT1:   accept = s;
        WAIT0:   accept = ~s;
        default: accept = 1'b0;
      endcase
    end
  end

  // Debounce FSM with registered level and single-cycle edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ZERO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ZERO: begin
          if (s) begin
            state <= WAIT1;
            cnt   <= '0;
          end
        end
        WAIT1: begin
          if (!s) begin
            state <= ZERO;
          end else if (accept) begin
            state <= ONE;
            level <= 1'b1;
            rise  <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        ONE: begin
          if (!s) begin
            state <= WAIT0;
            cnt   <= '0;
          end
        end
        WAIT0: begin
          if (s) begin
            state <= ONE;
          end else if (accept) begin
            state <= ZERO;
            level <= 1'b0;
            fall  <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ZERO;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of NCH independent switch debouncers sharing one sample-tick prescaler.
// Optional feature macro: DEBOUNCE_SYNC_EN -- when defined, each sw bit passes
// through a 2-flop synchronizer before the debouncer; when undefined, sw is
// assumed already synchronous to clk and is used directly.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NCH          = 8,
  parameter int TICK_DIV     = 1000000,
  parameter int STABLE_TICKS = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           changed
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]  presc;
  logic           tick;
  logic [NCH-1:0] s;
  logic [NCH-1:0] accept;

`ifdef DEBOUNCE_SYNC_EN
  logic [NCH-1:0] sync_meta;
  logic [NCH-1:0] sync_out;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: synchronizer flops are reset so no stale level survives reset.
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= sw;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = sw;
`endif

  // Shared prescaler: free-running 0..TICK_DIV-1, wraps to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .s      (s[i]),
      .tick   (tick),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .accept (accept[i])
    );
  end

  // Bank-wide change flag, registered on the same edge as the channel pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank (NCH=4, TICK_DIV=4, STABLE_TICKS=3).
// Stimulus pushes expected pulse events with an acceptance window; a monitor
// pops and compares each time the DUT raises changed.
module tb_debounce_bank;

  localparam int NCH          = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Window, in cycles after the edge that first samples the new sw value.
  localparam int LAT_LO = SYNC_LAT + (STABLE_TICKS - 1) * TICK_DIV + 1;
  localparam int LAT_HI = SYNC_LAT + STABLE_TICKS * TICK_DIV;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           changed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string          name;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] level;
    int             lo;
    int             hi;
  } exp_t;

  exp_t exp_q[$];

  debounce_bank #(
    .NCH         (NCH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw     (sw),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue an expected pulse for a stimulus applied before the next rising edge.
  task automatic expect_pulse(input string name, input logic [NCH-1:0] r,
                              input logic [NCH-1:0] f, input logic [NCH-1:0] l);
    exp_t e;
    e.name  = name;
    e.rise  = r;
    e.fall  = f;
    e.level = l;
    e.lo    = cyc + 1 + LAT_LO;
    e.hi    = cyc + 1 + LAT_HI;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: per-cycle invariants, and scoreboard pop on every changed pulse.
  always @(negedge clk) begin
    check("rise_fall_exclusive", 32'(rise & fall), 32'd0);
    check("changed_is_or", 32'(changed), 32'(|(rise | fall)));
    if (changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(changed), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rise"}, 32'(rise), 32'(e.rise));
        check({e.name, "_fall"}, 32'(fall), 32'(e.fall));
        check({e.name, "_level"}, 32'(level), 32'(e.level));
        check({e.name, "_window"}, 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
      end
    end
  end

  initial begin
    sw      = '0;
    reset_n = 1'b0;
    wait_cycles(3);
    check("reset_level", 32'(level), 32'd0);
    check("reset_rise", 32'(rise), 32'd0);
    check("reset_fall", 32'(fall), 32'd0);
    check("reset_changed", 32'(changed), 32'd0);
    reset_n = 1'b1;
    wait_cycles(6);

    // Channel 0 rises and is held: one rise pulse inside the window.
    sw[0] = 1'b1;
    expect_pulse("ch0_rise", 4'b0001, 4'b0000, 4'b0001);
    wait_cycles(20);
    check("ch0_level_held", 32'(level), 32'b0001);
    check("ch0_drained", 32'(exp_q.size()), 32'd0);

    // Channel 1 glitch of 5 cycles: never accepted, no pulse.
    sw[1] = 1'b1;
    wait_cycles(5);
    sw[1] = 1'b0;
    wait_cycles(25);
    check("ch1_glitch_level", 32'(level), 32'b0001);

    // Channels 2 and 3 rise together: single combined pulse.
    sw[3:2] = 2'b11;
    expect_pulse("ch23_rise", 4'b1100, 4'b0000, 4'b1101);
    wait_cycles(20);
    check("ch23_level", 32'(level), 32'b1101);
    check("ch23_drained", 32'(exp_q.size()), 32'd0);

    // Channel 0 dips low for 6 cycles: stays accepted high, no fall.
    sw[0] = 1'b0;
    wait_cycles(6);
    sw[0] = 1'b1;
    wait_cycles(25);
    check("ch0_dip_level", 32'(level), 32'b1101);

    // Channel 0 goes low and stays low: one fall pulse.
    sw[0] = 1'b0;
    expect_pulse("ch0_fall", 4'b0000, 4'b0001, 4'b1100);
    wait_cycles(20);
    check("ch0_fall_level", 32'(level), 32'b1100);
    check("ch0_fall_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-WAIT1 on channel 1, asynchronously mid-cycle.
    sw[1] = 1'b1;
    wait_cycles(5);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_level", 32'(level), 32'd0);
    check("rst_async_rise", 32'(rise), 32'd0);
    check("rst_async_fall", 32'(fall), 32'd0);
    check("rst_async_changed", 32'(changed), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_level", 32'(level), 32'd0);
      check("rst_hold_changed", 32'(changed), 32'd0);
    end
    // Release: channels 1..3 are still high and must re-qualify together.
    reset_n = 1'b1;
    expect_pulse("post_reset_rise", 4'b1110, 4'b0000, 4'b1110);
    wait_cycles(20);
    check("post_reset_level", 32'(level), 32'b1110);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
